// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
//   - DEF_* : default 640x480@60 timing (100 MHz clk, 25 MHz pixel)
//   - SYNC_ACTIVE_LOW / SYNC_ACTIVE_HIGH : sync polarity selectors
//   - h_total / v_total : derived line and frame lengths
//   - counter_width : bits needed to count 0..n-1 (never less than 1)
package vga_timing_pkg;

    localparam int DEF_CLK_PER_PIX = 4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// Generic wrap-around counter used for the pixel prescaler and for the
// horizontal and vertical raster axes.
// Ports:
//   clk     - clock
//   reset   - asynchronous, active-high reset (count -> 0)
//   inc_i   - advance the count by one this clk
//   count_o - current count, 0..LIMIT-1
//   wrap_o  - combinational, high when inc_i && count_o == LIMIT-1
// With LIMIT=1 the count is constantly 0 and wrap_o follows inc_i.
module vga_axis_counter #(
    parameter int LIMIT = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = inc_i && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. A pixel prescaler feeds a
// horizontal counter which feeds a vertical counter; every output is a
// register loaded each clk from the counters, so all outputs are mutually
// aligned one clk behind the counters.
// Region order on both axes: active, front porch, sync, back porch.
// Ports:
//   clk, reset       - clock; asynchronous active-high reset
//   enable           - run; low freezes counters and outputs, strobes go 0
//   hsync, vsync     - sync outputs, active level H_POL / V_POL
//   video_on         - inside the visible area
//   pix_x, pix_y     - current horizontal / vertical count
//   pix_tick         - last clk of each pixel
//   line_start       - first clk of each line
//   frame_start      - first clk of each frame
//   frame_cnt        - frame counter, only when VGA_TIMING_FRAME_CNT_EN
//                      is defined
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_PER_PIX = DEF_CLK_PER_PIX,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic H_POL       = SYNC_ACTIVE_LOW,
    parameter logic V_POL       = SYNC_ACTIVE_LOW,
    parameter int   XW          = 10,
    parameter int   YW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int PW      = counter_width(CLK_PER_PIX);

    // Region boundaries; all are below the axis total so they fit the width.
    localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_PER_PIX < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 ||
        H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
    begin : g_bad_timing
        $error("vga_timing_gen: timing parameters must all be non-zero");
    end

    if ((H_TOTAL - 1) >= (1 << XW) || (V_TOTAL - 1) >= (1 << YW))
    begin : g_bad_width
        $error("vga_timing_gen: XW/YW too narrow for the raster totals");
    end

    // Counter chain: prescaler -> h -> v.
    logic [PW-1:0] presc_cnt;
    logic          presc_wrap;
    logic [XW-1:0] h_cnt;
    logic          h_wrap;
    logic [YW-1:0] v_cnt;
    logic          v_wrap;

    vga_axis_counter #(.LIMIT(CLK_PER_PIX), .W(PW)) u_presc (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (enable),
        .count_o (presc_cnt),
        .wrap_o  (presc_wrap)
    );

    vga_axis_counter #(.LIMIT(H_TOTAL), .W(XW)) u_h (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (presc_wrap),
        .count_o (h_cnt),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(.LIMIT(V_TOTAL), .W(YW)) u_v (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (h_wrap),
        .count_o (v_cnt),
        .wrap_o  (v_wrap)
    );

    // Output decode from the current counters.
    logic          hsync_d, vsync_d, video_on_d;
    logic          pix_tick_d, line_start_d, frame_start_d;
    logic [XW-1:0] pix_x_d;
    logic [YW-1:0] pix_y_d;

    always_comb begin
        pix_x_d       = h_cnt;
        pix_y_d       = v_cnt;
        video_on_d    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hsync_d       = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END))
                        ? H_POL : ~H_POL;
        vsync_d       = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END))
                        ? V_POL : ~V_POL;
        // presc_wrap already carries enable.
        pix_tick_d    = presc_wrap;
        line_start_d  = enable && (presc_cnt == '0) && (h_cnt == '0);
        frame_start_d = line_start_d && (v_cnt == '0);
    end

    logic          hsync_q, vsync_q, video_on_q;
    logic          pix_tick_q, line_start_q, frame_start_q;
    logic [XW-1:0] pix_x_q;
    logic [YW-1:0] pix_y_q;

    // Counters hold while disabled, so reloading every clk keeps the level
    // outputs frozen and forces the strobes to 0 without a separate hold path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            video_on_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_tick    = pix_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // fcnt tracks the counters (bumps when v wraps); frame_cnt_q is its copy
    // in the output stage, so it changes in the same cycle as frame_start.
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] frame_cnt_q;

    always_comb begin
        fcnt_d = fcnt_q;
        if (v_wrap) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            fcnt_q      <= fcnt_d;
            frame_cnt_q <= fcnt_q;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic en_d  = 1'b0;
    logic rst_s = 1'b1;
    logic en_s  = 1'b0;

    // default-configuration DUT
    logic       hs_d, vs_d, von_d, pt_d, ls_d, fs_d;
    logic [9:0] x_d;
    logic [9:0] y_d;
    // small-configuration DUT
    logic       hs_s, vs_s, von_s, pt_s, ls_s, fs_s;
    logic [3:0] x_s;
    logic [2:0] y_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_d, fc_s;
`endif

    vga_timing_gen dut_d (
        .clk         (clk),
        .reset       (rst_d),
        .enable      (en_d),
        .hsync       (hs_d),
        .vsync       (vs_d),
        .video_on    (von_d),
        .pix_x       (x_d),
        .pix_y       (y_d),
        .pix_tick    (pt_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_d)
`endif
    );

    vga_timing_gen #(
        .CLK_PER_PIX(1),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .XW(4), .YW(3)
    ) dut_s (
        .clk         (clk),
        .reset       (rst_s),
        .enable      (en_s),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .video_on    (von_s),
        .pix_x       (x_s),
        .pix_y       (y_s),
        .pix_tick    (pt_s),
        .line_start  (ls_s),
        .frame_start (fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_s)
`endif
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // small-config vectors: sample index after reset release -> outputs
    typedef struct {
        int cyc;
        int x;
        int y;
        int von;
        int hs;
        int vs;
        int ls;
        int fs;
    } vec_t;

    vec_t vecs[14];

    int cnt;
    int von_cnt;
    int hs_first;
    int hs_cnt;
    int cur;

    initial begin
        // H total 12, V total 7: hsync low for x 9..10, vsync low on y 5
        vecs[0]  = '{0,  0,  0, 1, 1, 1, 1, 1};
        vecs[1]  = '{7,  7,  0, 1, 1, 1, 0, 0};
        vecs[2]  = '{8,  8,  0, 0, 1, 1, 0, 0};
        vecs[3]  = '{9,  9,  0, 0, 0, 1, 0, 0};
        vecs[4]  = '{10, 10, 0, 0, 0, 1, 0, 0};
        vecs[5]  = '{11, 11, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{12, 0,  1, 1, 1, 1, 1, 0};
        vecs[7]  = '{47, 11, 3, 0, 1, 1, 0, 0};
        vecs[8]  = '{48, 0,  4, 0, 1, 1, 1, 0};
        vecs[9]  = '{60, 0,  5, 0, 1, 0, 1, 0};
        vecs[10] = '{72, 0,  6, 0, 1, 1, 1, 0};
        vecs[11] = '{83, 11, 6, 0, 1, 1, 0, 0};
        vecs[12] = '{84, 0,  0, 1, 1, 1, 1, 1};
        vecs[13] = '{93, 9,  0, 0, 0, 1, 0, 0};

        // ---- reset state, both DUTs ----
        repeat (3) @(negedge clk);
        check("rst_hsync", int'(hs_d), 1);
        check("rst_vsync", int'(vs_d), 1);
        check("rst_video_on", int'(von_d), 0);
        check("rst_pix_x", int'(x_d), 0);
        check("rst_pix_y", int'(y_d), 0);
        check("rst_line_start", int'(ls_d), 0);
        check("rst_frame_start", int'(fs_d), 0);
        check("rst_pix_tick", int'(pt_d), 0);
        check("rst_s_hsync", int'(hs_s), 1);
        check("rst_s_video_on", int'(von_s), 0);

        // ---- release with enable=1 ----
        en_d  = 1'b1;
        rst_d = 1'b0;
        @(negedge clk);
        check("first_pix_x", int'(x_d), 0);
        check("first_pix_y", int'(y_d), 0);
        check("first_video_on", int'(von_d), 1);
        check("first_line_start", int'(ls_d), 1);
        check("first_frame_start", int'(fs_d), 1);
        check("first_pix_tick", int'(pt_d), 0);
        @(negedge clk);
        check("second_frame_start", int'(fs_d), 0);
        check("second_line_start", int'(ls_d), 0);
        check("second_pix_x", int'(x_d), 0);
        @(negedge clk);
        @(negedge clk);
        check("fourth_pix_tick", int'(pt_d), 1);
        check("fourth_pix_x", int'(x_d), 0);
        @(negedge clk);
        check("fifth_pix_x", int'(x_d), 1);

        // ---- wait for line 1 start ----
        cnt = 0;
        while (!ls_d && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("line1_start_at", cnt, 3200 - 4);
        check("line1_pix_y", int'(y_d), 1);

        // ---- measure line 1 ----
        cnt = 0; von_cnt = 0; hs_first = -1; hs_cnt = 0;
        do begin
            if (von_d) von_cnt++;
            if (!hs_d) begin
                if (hs_first < 0) hs_first = cnt;
                hs_cnt++;
            end
            @(negedge clk);
            cnt++;
        end while (!ls_d && cnt < 5000);
        check("line_period", cnt, 3200);
        check("line_video_on_clks", von_cnt, 2560);
        check("line_hsync_offset", hs_first, 2624);
        check("line_hsync_clks", hs_cnt, 384);
        check("line2_frame_start", int'(fs_d), 0);
        check("line2_pix_y", int'(y_d), 2);

        // ---- enable gap at pix_x=300 on line 2 ----
        cnt = 0;
        while (x_d != 10'd300 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("gap_reach_x300", cnt, 1200);
        en_d = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            check("gap_pix_x", int'(x_d), 300);
            check("gap_pix_y", int'(y_d), 2);
            check("gap_video_on", int'(von_d), 1);
            check("gap_hsync", int'(hs_d), 1);
            check("gap_strobes", int'({pt_d, ls_d, fs_d}), 0);
        end
        en_d = 1'b1;
        while (!ls_d && cnt < 8000) begin
            @(negedge clk);
            cnt++;
        end
        check("gap_line_period", cnt, 3300);
        check("line3_pix_y", int'(y_d), 3);

        // ---- async reset mid-line, during hsync ----
        cnt = 0;
        while (x_d != 10'd700 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("pre_reset_hsync", int'(hs_d), 0);
        check("pre_reset_video_on", int'(von_d), 0);
        #2;
        rst_d = 1'b1;
        #1;
        check("async_hsync", int'(hs_d), 1);
        check("async_vsync", int'(vs_d), 1);
        check("async_pix_x", int'(x_d), 0);
        check("async_pix_y", int'(y_d), 0);
        check("async_video_on", int'(von_d), 0);
        check("async_strobes", int'({pt_d, ls_d, fs_d}), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("async_frame_cnt", int'(fc_d), 0);
`endif
        @(negedge clk);
        rst_d = 1'b0;
        @(negedge clk);
        check("restart_pix_x", int'(x_d), 0);
        check("restart_pix_y", int'(y_d), 0);
        check("restart_video_on", int'(von_d), 1);
        check("restart_frame_start", int'(fs_d), 1);

        // ---- small configuration, table-driven ----
        en_s  = 1'b1;
        rst_s = 1'b0;
        @(negedge clk);
        cur = 0;
        check("s_pix_tick", int'(pt_s), 1);
        for (int i = 0; i < 14; i++) begin
            while (cur < vecs[i].cyc) begin
                @(negedge clk);
                cur++;
                check("s_pix_tick", int'(pt_s), 1);
                // frame_start only at multiples of the 84-clk frame
                check("s_frame_start_any", int'(fs_s),
                      ((cur % 84) == 0) ? 1 : 0);
            end
            check("s_pix_x", int'(x_s), vecs[i].x);
            check("s_pix_y", int'(y_s), vecs[i].y);
            check("s_video_on", int'(von_s), vecs[i].von);
            check("s_hsync", int'(hs_s), vecs[i].hs);
            check("s_vsync", int'(vs_s), vecs[i].vs);
            check("s_line_start", int'(ls_s), vecs[i].ls);
            check("s_frame_start", int'(fs_s), vecs[i].fs);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("s_frame_cnt", int'(fc_s), 1);
`endif

        // small config: disabled clk drops pix_tick
        en_s = 1'b0;
        @(negedge clk);
        check("s_disabled_pix_tick", int'(pt_s), 0);
        check("s_disabled_pix_x", int'(x_s), 10);
        en_s = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator.
- Combines pixel prescaler, horizontal counter and vertical counter; decodes hsync, vsync, video_on, pixel coordinates and line/frame strobes.
- Sits between the system clock domain and the pixel pipeline and VGA output pins.
- Timing fully set by parameters; defaults give 640x480@60 from a 4x pixel-rate clock (100 MHz clk, 25 MHz pixel).

Parameters:
- CLK_PER_PIX, 4, clk cycles per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- XW, 10, pix_x width; must hold H_TOTAL-1
- YW, 10, pix_y width; must hold V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  run; low freezes all state
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- video_on  out  1  high inside the active area
- pix_x  out  XW  current horizontal pixel count, 0..H_TOTAL-1
- pix_y  out  YW  current line count, 0..V_TOTAL-1
- pix_tick  out  1  high on the last clk of each pixel
- line_start  out  1  1-clk pulse on the first clk of each line
- frame_start  out  1  1-clk pulse on the first clk of each frame

Behaviour:
- Totals: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 and 521.
- Region order in each axis: active, front porch, sync, back porch.
- Internal counters:
  - presc counts 0..CLK_PER_PIX-1 when enable=1, then wraps to 0.
  - h increments when enable and presc==CLK_PER_PIX-1; wraps H_TOTAL-1 -> 0.
  - v increments when h wraps; wraps V_TOTAL-1 -> 0.
  - With CLK_PER_PIX=1, presc is a constant 0 and every enabled clk advances h.
- Output stage: every output is a register loaded each clk from the current internal counters. Latency is 1 clk behind the counters, and all outputs are mutually aligned.
- Output decodes:
  - pix_x = h; pix_y = v.
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v.
  - pix_tick = enable && presc==CLK_PER_PIX-1.
  - line_start = enable && presc==0 && h==0.
  - frame_start = line_start && v==0.
- enable=0: counters hold and outputs hold their values. Strobes pix_tick, line_start and frame_start are 0 while disabled. Counting resumes exactly where it stopped.
- Reset (asynchronous, immediate, including mid-frame):
  - counters = 0; pix_x = 0; pix_y = 0; video_on = 0.
  - hsync = ~H_POL; vsync = ~V_POL.
  - pix_tick, line_start, frame_start = 0.
  - On the first clk edge after release with enable=1, outputs show (0,0), video_on=1, and line_start=frame_start=1.
- Simultaneous h and v wrap: both go to 0 on the same edge; the next output cycle pulses frame_start.
- Parameter check: elaboration-time error if any timing parameter is 0 (CLK_PER_PIX >= 1 is still allowed), or if XW or YW is too narrow.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output port frame_cnt [15:0]. Resets to 0, increments on the same edge the v counter wraps, and wraps 65535 -> 0. It is registered, so it changes in the same output cycle as frame_start.
- Undefined: the port and its logic are absent; everything else is unchanged.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 timing constants;
  - derived H_TOTAL/V_TOTAL helper functions;
  - polarity constants SYNC_ACTIVE_LOW/HIGH.
- Sub-module vga_axis_counter: generic wrap counter with parameters LIMIT and W. Ports: inc enable in, count out, wrap out (combinational, high when inc && count==LIMIT-1).
- Instantiated twice (H and V); the prescaler is a small third instance or inline logic.

Test Plan:
- Reset: with reset held, outputs hsync=1, vsync=1, video_on=0, pix_x=pix_y=0. Release with enable=1 -> next clk pix_x=0, pix_y=0, video_on=1, frame_start=1 for exactly 1 clk.
- Line timing (defaults): line_start period 3200 clk; video_on high 2560 clk per active line; hsync low for 384 clk starting 2624 clk after line_start.
- Frame timing (defaults): frame_start period 1,667,200 clk; vsync low 6400 clk starting 1,568,000 clk after frame_start; video_on stays 0 for lines 480..520.
- Enable gap: drop enable for 100 clk at pix_x=300 -> all outputs frozen, strobes 0; that line measures 3300 clk.
- Async reset at pix_y=250 mid-line -> outputs reach reset values without a clk edge; restart at (0,0). With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt returns to 0.
- Small config: CLK_PER_PIX=1, H 8/1/2/1, V 4/1/1/1 -> pix_tick always high when enabled, line period 12 clk, frame period 84 clk, hsync active for pix_x 9..10.
